dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for a data cache: accepts one request,
// waits LATENCY cycles, then pulses dcache_rdy with the read or post-write word.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dcache_addr,
    input  logic [31:0] dcache_wdata,
    input  logic [1:0]  dcache_ws,
    input  logic        dcache_req,
    input  logic        dcache_wr,
    output logic [31:0] dcache_rdata,
    output logic        dcache_rdy,
    output logic        dcache_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Handshake: a request is taken when dcache_req=1 at a rising edge in IDLE;
    // dcache_rdy=1 for exactly one cycle marks completion, and dcache_err and
    // dcache_rdata are meaningful in that cycle. Requests outside IDLE are ignored.
    state_t      state;
    state_t      state_next;
    logic [3:0]  count;
    logic [3:0]  count_next;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  ws_q;
    logic        wr_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic          out_of_range;
    logic          misaligned;
    logic          bad;
    logic          commit;
    logic [3:0]    byte_en;
    logic [31:0]   lane_data;
    logic [31:0]   cur_word;
    logic [31:0]   merged;
    logic [31:0]   rdata_q;
    logic          err_q;

    assign idx          = addr_q[AW+1:2];
    assign out_of_range = |addr_q[31:AW+2];
    assign bad          = misaligned | out_of_range;
    assign cur_word     = mem[idx];

    always_comb begin
        misaligned = 1'b0;
        if (ws_q == 2'b01)
            misaligned = addr_q[0];
        else if (ws_q[1])
            misaligned = (addr_q[1:0] != 2'b00);
    end

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        byte_en   = 4'b1111;
        lane_data = wdata_q;
        case (ws_q)
            2'b00: begin
                byte_en   = 4'b0001 << addr_q[1:0];
                lane_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_q[15:0]}};
            end
            default: begin
                byte_en   = 4'b1111;
                lane_data = wdata_q;
            end
        endcase
    end

    always_comb begin
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i])
                merged[8*i +: 8] = lane_data[8*i +: 8];
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (dcache_req) begin
                    state_next = WAIT;
                    count_next = 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (count == 4'd0)
                    state_next = RESP;
                else
                    count_next = count - 4'd1;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign commit = (state == WAIT) && (count == 4'd0) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && state == IDLE && dcache_req) begin
            addr_q  <= dcache_addr;
            wdata_q <= dcache_wdata;
            ws_q    <= dcache_ws;
            wr_q    <= dcache_wr;
        end
    end

    // Memory is deliberately left out of reset so contents survive it.
    always_ff @(posedge clock) begin
        if (commit && wr_q && !bad)
            mem[idx] <= merged;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (commit) begin
            if (wr_q)
                rdata_q <= bad ? 32'd0 : merged;
            else
                rdata_q <= out_of_range ? 32'd0 : cur_word;
            err_q <= bad;
        end else begin
            err_q <= 1'b0;
        end
    end

    assign dcache_rdata = rdata_q;
    assign dcache_rdy   = (state == RESP);
    assign dcache_err   = err_q;
endmodule
